// File: rtl/ec_point_sub.sv
// ============================================================================
// Module      : ec_point_sub
// Description : Iterative elliptic-curve point subtraction R = P - Q over GF(p)
//               using one binary modular inverter and one serial multiplier.
//               Optional macro ECSUB_OPERAND_CHECK_EN adds an operand range check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ec_point_sub #(
   parameter int integer_size = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    go,
   input  logic [integer_size-1:0] prime,
   input  logic [integer_size-1:0] Px,
   input  logic [integer_size-1:0] Py,
   input  logic [integer_size-1:0] Qx,
   input  logic [integer_size-1:0] Qy,
   input  logic                    infiniteP,
   input  logic                    infiniteQ,
   output logic [integer_size-1:0] PQx,
   output logic [integer_size-1:0] PQy,
   output logic                    infinitePQ,
   output logic                    err,
   output logic                    busy,
   output logic                    done
);

   localparam int c_w  = integer_size;
   localparam int c_cw = $clog2(2 * integer_size + 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CLASSIFY = 3'd1,
      S_INV      = 3'd2,
      S_MUL1     = 3'd3,
      S_MUL2     = 3'd4,
      S_MUL3     = 3'd5,
      S_FINISH   = 3'd6
   } state_t;

   function automatic logic [c_w-1:0] f_add(input logic [c_w-1:0] a, input logic [c_w-1:0] b,
                                             input logic [c_w-1:0] m);
      logic [c_w:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, m}) s = s - {1'b0, m};
      return s[c_w-1:0];
   endfunction

   function automatic logic [c_w-1:0] f_sub(input logic [c_w-1:0] a, input logic [c_w-1:0] b,
                                             input logic [c_w-1:0] m);
      logic [c_w:0] d;
      d = {1'b0, a} - {1'b0, b};
      if (d[c_w]) d = d + {1'b0, m};
      return d[c_w-1:0];
   endfunction

   // Halving mod p: odd values become (x + p) / 2, which is exact since p is odd.
   function automatic logic [c_w-1:0] f_half(input logic [c_w-1:0] x, input logic [c_w-1:0] m);
      logic [c_w:0] s;
      s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
      return c_w'(s >> 1);
   endfunction

   function automatic logic [c_w-1:0] f_neg(input logic [c_w-1:0] y, input logic [c_w-1:0] m);
      return (y == '0) ? '0 : (m - y);
   endfunction

   state_t           state_q, state_d;
   logic [c_w-1:0]   p_q, p_d, px_q, px_d, py_q, py_d, qx_q, qx_d, qy_q, qy_d;
   logic             infp_q, infp_d, infq_q, infq_d;
   logic [c_w-1:0]   u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d;
   logic [c_w-1:0]   ma_q, ma_d, mb_q, mb_d, acc_q, acc_d, rx_q, rx_d;
   logic [c_cw-1:0]  cnt_q, cnt_d;
   logic [c_w-1:0]   pqx_q, pqx_d, pqy_q, pqy_d;
   logic             infpq_q, infpq_d, err_q, err_d;

   logic [c_w-1:0]   w_dbl, w_prod;
   logic             w_mul_last, w_inv_done;

   // One MSB-first double-and-add step of the serial multiplier.
   assign w_dbl      = f_add(acc_q, acc_q, p_q);
   assign w_prod     = mb_q[c_w-1] ? f_add(w_dbl, ma_q, p_q) : w_dbl;
   assign w_mul_last = (cnt_q == c_cw'(c_w - 1));
   assign w_inv_done = (u_q == c_w'(1)) || (v_q == c_w'(1)) || (cnt_q == c_cw'(2 * c_w));

`ifdef ECSUB_OPERAND_CHECK_EN
   logic w_range_bad;
   assign w_range_bad = (!infp_q && ((px_q >= p_q) || (py_q >= p_q))) ||
                        (!infq_q && ((qx_q >= p_q) || (qy_q >= p_q)));
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         p_q     <= '0;
         px_q    <= '0;
         py_q    <= '0;
         qx_q    <= '0;
         qy_q    <= '0;
         infp_q  <= 1'b0;
         infq_q  <= 1'b0;
         u_q     <= '0;
         v_q     <= '0;
         x1_q    <= '0;
         x2_q    <= '0;
         ma_q    <= '0;
         mb_q    <= '0;
         acc_q   <= '0;
         rx_q    <= '0;
         cnt_q   <= '0;
         pqx_q   <= '0;
         pqy_q   <= '0;
         infpq_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         px_q    <= px_d;
         py_q    <= py_d;
         qx_q    <= qx_d;
         qy_q    <= qy_d;
         infp_q  <= infp_d;
         infq_q  <= infq_d;
         u_q     <= u_d;
         v_q     <= v_d;
         x1_q    <= x1_d;
         x2_q    <= x2_d;
         ma_q    <= ma_d;
         mb_q    <= mb_d;
         acc_q   <= acc_d;
         rx_q    <= rx_d;
         cnt_q   <= cnt_d;
         pqx_q   <= pqx_d;
         pqy_q   <= pqy_d;
         infpq_q <= infpq_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      px_d    = px_q;
      py_d    = py_q;
      qx_d    = qx_q;
      qy_d    = qy_q;
      infp_d  = infp_q;
      infq_d  = infq_q;
      u_d     = u_q;
      v_d     = v_q;
      x1_d    = x1_q;
      x2_d    = x2_q;
      ma_d    = ma_q;
      mb_d    = mb_q;
      acc_d   = acc_q;
      rx_d    = rx_q;
      cnt_d   = cnt_q;
      pqx_d   = pqx_q;
      pqy_d   = pqy_q;
      infpq_d = infpq_q;
      err_d   = err_q;

      case (state_q)
         S_IDLE: begin
            if (go) begin
               p_d     = prime;
               px_d    = Px;
               py_d    = Py;
               qx_d    = Qx;
               qy_d    = Qy;
               infp_d  = infiniteP;
               infq_d  = infiniteQ;
               state_d = S_CLASSIFY;
            end
         end

         S_CLASSIFY: begin
            state_d = S_FINISH;
            pqx_d   = '0;
            pqy_d   = '0;
            infpq_d = 1'b0;
            err_d   = 1'b0;
`ifdef ECSUB_OPERAND_CHECK_EN
            if (w_range_bad) begin
               err_d = 1'b1;
            end else
`endif
            if (infq_q) begin
               pqx_d   = px_q;
               pqy_d   = py_q;
               infpq_d = infp_q;
            end else if (infp_q) begin
               pqx_d = qx_q;
               pqy_d = f_neg(qy_q, p_q);
            end else if ((px_q == qx_q) && (py_q == qy_q)) begin
               infpq_d = 1'b1;
            end else if (px_q == qx_q) begin
               err_d = 1'b1;
            end else begin
               // Adding -Q turns the numerator Py - (p - Qy) into Py + Qy.
               u_d     = f_sub(px_q, qx_q, p_q);
               v_d     = p_q;
               x1_d    = c_w'(1);
               x2_d    = '0;
               ma_d    = f_add(py_q, qy_q, p_q);
               cnt_d   = '0;
               state_d = S_INV;
            end
         end

         S_INV: begin
            if (w_inv_done) begin
               mb_d    = (u_q == c_w'(1)) ? x1_q : x2_q;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = S_MUL1;
            end else begin
               // Invariants: x1*den == u and x2*den == v (mod p); every step halves u or v.
               cnt_d = cnt_q + c_cw'(1);
               if (!u_q[0]) begin
                  u_d  = u_q >> 1;
                  x1_d = f_half(x1_q, p_q);
               end else if (!v_q[0]) begin
                  v_d  = v_q >> 1;
                  x2_d = f_half(x2_q, p_q);
               end else if (u_q >= v_q) begin
                  u_d  = (u_q - v_q) >> 1;
                  x1_d = f_half(f_sub(x1_q, x2_q, p_q), p_q);
               end else begin
                  v_d  = (v_q - u_q) >> 1;
                  x2_d = f_half(f_sub(x2_q, x1_q, p_q), p_q);
               end
            end
         end

         S_MUL1, S_MUL2, S_MUL3: begin
            acc_d = w_prod;
            mb_d  = mb_q << 1;
            cnt_d = cnt_q + c_cw'(1);
            if (w_mul_last) begin
               acc_d = '0;
               cnt_d = '0;
               case (state_q)
                  S_MUL1: begin
                     ma_d    = w_prod;
                     mb_d    = w_prod;
                     state_d = S_MUL2;
                  end
                  S_MUL2: begin
                     rx_d    = f_sub(f_sub(w_prod, px_q, p_q), qx_q, p_q);
                     mb_d    = f_sub(px_q, f_sub(f_sub(w_prod, px_q, p_q), qx_q, p_q), p_q);
                     state_d = S_MUL3;
                  end
                  default: begin
                     pqx_d   = rx_q;
                     pqy_d   = f_sub(w_prod, py_q, p_q);
                     infpq_d = 1'b0;
                     err_d   = 1'b0;
                     state_d = S_FINISH;
                  end
               endcase
            end
         end

         S_FINISH: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign PQx        = pqx_q;
   assign PQy        = pqy_q;
   assign infinitePQ = infpq_q;
   assign err        = err_q;
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_FINISH);

endmodule

`default_nettype wire

// File: tb/tb_ec_point_sub.sv
// Directed checks of ec_point_sub on y^2 = x^3 + 2x + 2 over GF(17), 8-bit operands.
`default_nettype none

module tb_ec_point_sub;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         go = 1'b0;
   logic [W-1:0] prime = 8'd17;
   logic [W-1:0] Px = '0, Py = '0, Qx = '0, Qy = '0;
   logic         infiniteP = 1'b0, infiniteQ = 1'b0;
   logic [W-1:0] PQx, PQy;
   logic         infinitePQ, err, busy, done;

   int n_checks = 0;
   int n_fail   = 0;

   ec_point_sub #(.integer_size(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .go         (go),
      .prime      (prime),
      .Px         (Px),
      .Py         (Py),
      .Qx         (Qx),
      .Qy         (Qy),
      .infiniteP  (infiniteP),
      .infiniteQ  (infiniteQ),
      .PQx        (PQx),
      .PQy        (PQy),
      .infinitePQ (infinitePQ),
      .err        (err),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [W-1:0] px, input logic [W-1:0] py, input logic [W-1:0] qx,
                        input logic [W-1:0] qy, input logic ip, input logic iq);
      Px = px;
      Py = py;
      Qx = qx;
      Qy = qy;
      infiniteP = ip;
      infiniteQ = iq;
   endtask

   task automatic launch();
      go = 1'b1;
      @(posedge clk);
      #1;
      go = 1'b0;
   endtask

   // lat counts edges since the one that accepted go.
   task automatic wait_done(input string tag, output int lat);
      lat = 1;
      while (done !== 1'b1 && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "_done"}, 64'(done), 64'(1));
   endtask

   task automatic run(input string tag, input logic [W-1:0] px, input logic [W-1:0] py,
                      input logic [W-1:0] qx, input logic [W-1:0] qy, input logic ip,
                      input logic iq, input logic [W-1:0] ex, input logic [W-1:0] ey,
                      input logic einf, input logic eerr, input int elat);
      int lat;
      drive(px, py, qx, qy, ip, iq);
      launch();
      check({tag, "_busy_start"}, 64'(busy), 64'(1));
      wait_done(tag, lat);
      check({tag, "_x"}, 64'(PQx), 64'(ex));
      check({tag, "_y"}, 64'(PQy), 64'(ey));
      check({tag, "_inf"}, 64'(infinitePQ), 64'(einf));
      check({tag, "_err"}, 64'(err), 64'(eerr));
      check({tag, "_busy_done"}, 64'(busy), 64'(1));
      if (elat > 0) check({tag, "_lat"}, 64'(lat), 64'(elat));
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, 64'(done), 64'(0));
      check({tag, "_busy_idle"}, 64'(busy), 64'(0));
   endtask

   initial begin
      int lat;
      int extra;

      repeat (3) @(posedge clk);
      #1;
      check("rst_x", 64'(PQx), 64'(0));
      check("rst_y", 64'(PQy), 64'(0));
      check("rst_inf", 64'(infinitePQ), 64'(0));
      check("rst_err", 64'(err), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      rst = 1'b1;
      @(posedge clk);
      #1;

      // General cases; the second run is launched right after the first completes.
      run("gen_a", 8'd10, 8'd6, 8'd5, 8'd1, 1'b0, 1'b0, 8'd6, 8'd3, 1'b0, 1'b0, 0);
      run("gen_b", 8'd6, 8'd3, 8'd5, 8'd1, 1'b0, 1'b0, 8'd5, 8'd1, 1'b0, 1'b0, 0);
      run("gen_c", 8'd5, 8'd1, 8'd6, 8'd3, 1'b0, 1'b0, 8'd5, 8'd16, 1'b0, 1'b0, 0);
      run("gen_d", 8'd10, 8'd6, 8'd6, 8'd3, 1'b0, 1'b0, 8'd5, 8'd1, 1'b0, 1'b0, 0);

      // Special cases, each with two-cycle latency.
      run("same", 8'd5, 8'd1, 8'd5, 8'd1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 2);
      run("dbl", 8'd5, 8'd16, 8'd5, 8'd1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 2);
      run("infp", 8'd0, 8'd0, 8'd5, 8'd1, 1'b1, 1'b0, 8'd5, 8'd16, 1'b0, 1'b0, 2);
      run("both", 8'd0, 8'd0, 8'd5, 8'd1, 1'b1, 1'b1, 8'd0, 8'd0, 1'b1, 1'b0, 2);
      run("infq", 8'd9, 8'd16, 8'd5, 8'd1, 1'b0, 1'b1, 8'd9, 8'd16, 1'b0, 1'b0, 2);

      // Asynchronous reset while the inverter is running.
      drive(8'd10, 8'd6, 8'd5, 8'd1, 1'b0, 1'b0);
      launch();
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("arst_x", 64'(PQx), 64'(0));
      check("arst_y", 64'(PQy), 64'(0));
      check("arst_busy", 64'(busy), 64'(0));
      check("arst_done", 64'(done), 64'(0));
      repeat (3) begin
         @(posedge clk);
         #1;
         check("arst_nodone", 64'(done), 64'(0));
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      run("post_rst", 8'd6, 8'd3, 8'd5, 8'd1, 1'b0, 1'b0, 8'd5, 8'd1, 1'b0, 1'b0, 0);

      // A go pulse during an operation must be ignored.
      drive(8'd10, 8'd6, 8'd5, 8'd1, 1'b0, 1'b0);
      launch();
      repeat (3) @(posedge clk);
      #1;
      drive(8'd5, 8'd1, 8'd5, 8'd1, 1'b0, 1'b0);
      launch();
      wait_done("busy_go", lat);
      check("busy_go_x", 64'(PQx), 64'(6));
      check("busy_go_y", 64'(PQy), 64'(3));
      extra = 0;
      repeat (60) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) extra++;
      end
      check("busy_go_extra", 64'(extra), 64'(0));

      // Out-of-range Px.
`ifdef ECSUB_OPERAND_CHECK_EN
      run("range", 8'd18, 8'd1, 8'd5, 8'd1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 2);
`else
      drive(8'd18, 8'd1, 8'd5, 8'd1, 1'b0, 1'b0);
      launch();
      wait_done("range", lat);
      check("range_err", 64'(err), 64'(0));
      check("range_inf", 64'(infinitePQ), 64'(0));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
